// File: rtl/dat_mem_arb.sv
// dat_mem_arb: round-robin arbiter with bounded burst locking in front of a single-port data memory
module dat_mem_arb #(
    parameter int MAX_BURST = 4,
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_dout
);
    localparam logic [3:0] MB = 4'(MAX_BURST);
    logic       lg;
    logic       own_vld;
    logic       own_id;
    logic [3:0] burst_cnt;
    logic       any;
    logic       sel;
    logic       hold;
    logic       rv0_q;
    logic       rv1_q;
    // Grant decision: locked owner keeps the slot under the burst limit, otherwise alternate away from lg
    always_comb begin
        hold      = own_vld && (own_id ? lock1 : lock0) && (burst_cnt < MB);
        any       = !reset && (req0 || req1);
        sel       = (req0 && req1) ? (hold ? own_id : !lg) : req1;
        gnt0      = any && !sel;
        gnt1      = any && sel;
        mem_addr  = gnt1 ? addr1 : gnt0 ? addr0 : '0;
        mem_din   = gnt1 ? wdata1 : gnt0 ? wdata0 : '0;
        mem_wr_en = gnt1 ? we1 : gnt0 ? we0 : 1'b0;
    end
    // Arbitration history and the registered read return path
    always_ff @(posedge clk) begin
        if (reset) begin
            lg        <= 1'b1;
            own_vld   <= 1'b0;
            own_id    <= 1'b0;
            burst_cnt <= '0;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
            rdata     <= '0;
        end else begin
            if (any) begin
                lg        <= sel;
                own_id    <= sel;
                own_vld   <= 1'b1;
                burst_cnt <= (own_vld && own_id == sel) ? ((burst_cnt == MB) ? burst_cnt : burst_cnt + 4'd1) : 4'd1;
            end else begin
                own_vld   <= 1'b0;
                burst_cnt <= '0;
            end
            rv0_q <= gnt0 && !we0;
            rv1_q <= gnt1 && !we1;
            if ((gnt0 && !we0) || (gnt1 && !we1))
                rdata <= mem_dout;
        end
    end
    // A read granted just before reset must not report valid during the reset cycle
    always_comb begin
        rvalid0 = rv0_q && !reset;
        rvalid1 = rv1_q && !reset;
    end
endmodule

// File: doc/dat_mem_arb.md
Name: dat_mem_arb

Overview:
- Two-requester arbiter that shares the single-port 8x256 data memory between the core load/store path (requester 0) and a secondary master such as a test loader or DMA (requester 1).
- Sits directly in front of the data memory and drives its address, write-data and write-enable inputs.
- One memory access per cycle. Arbitration is round-robin, with optional bounded burst locking so one master can stream consecutive accesses.
- Read data comes back registered, one cycle after the grant.

Parameters:
- MAX_BURST, 4: maximum consecutive grants a locking requester keeps while the other requester is waiting (legal range 1..15).
- AW, 8: address width; must match memory depth 2^AW.
- DW, 8: data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request; held until gnt0 is seen.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- lock0  in  1  requester 0 asks to keep ownership for following cycles.
- req1, we1, addr1, wdata1, lock1  in  1/1/AW/DW/1  same signals for requester 1.
- gnt0  out  1  requester 0's access is performed this cycle.
- gnt1  out  1  requester 1's access is performed this cycle.
- rvalid0  out  1  rdata holds requester 0's read result.
- rvalid1  out  1  rdata holds requester 1's read result.
- rdata  out  DW  registered read data, shared by both requesters.
- mem_addr  out  AW  to memory addr.
- mem_din  out  DW  to memory dat_in.
- mem_wr_en  out  1  to memory wr_en.
- mem_dout  in  DW  from memory dat_out (combinational read).

Behaviour:
- Reset, while reset is high:
  - gnt0, gnt1 and mem_wr_en are forced 0.
  - mem_addr and mem_din are forced 0.
  - Next cycle: rvalid0 = rvalid1 = 0, rdata = 0.
  - Internal state: last-grant pointer lg = 1, so requester 0 wins the first tie; owner = none; burst_cnt = 0.
- Reset mid-operation: a write presented in the reset cycle is never issued (mem_wr_en = 0). A read granted in the cycle before reset does not produce rvalid.
- Grant decision is combinational in cycle t, from req*, lock* and the registered state:
  - Neither requesting: no grant; mem_wr_en = 0; mem_addr = 0, mem_din = 0.
  - Only one requesting: that one is granted.
  - Both requesting, and the previous cycle's owner k has lock_k = 1 and burst_cnt < MAX_BURST: k is granted.
  - Both requesting, otherwise: the requester != lg is granted.
- Winner path: the winner's addr, wdata and we drive mem_addr, mem_din and mem_wr_en in the same cycle. The memory write lands at the end of cycle t.
- Exactly one of gnt0/gnt1 may be high in any cycle; both high is an error the bench must flag.
- Registered on posedge after a grant to k:
  - lg <= k.
  - burst_cnt <= (k == owner) ? min(burst_cnt + 1, MAX_BURST) : 1.
  - owner <= k.
  - Cycles with no grant: owner <= none, burst_cnt <= 0.
- Burst limit: when burst_cnt == MAX_BURST and the other requester is waiting, the other requester wins the next cycle even if lock is held. If the other is not requesting, the owner keeps winning and burst_cnt saturates.
- Read latency is 1:
  - Granted read (we_k = 0) in cycle t: rdata <= mem_dout at posedge; rvalid_k = 1 for cycle t+1 only.
  - Granted writes produce no rvalid.
  - rdata holds its value when there is no read.
- Read-after-write to the same address on back-to-back grants returns the new data, since the write completes before the next cycle's combinational read.
- Requester protocol:
  - Inputs must stay stable while req is high and ungranted.
  - Deasserting req before grant withdraws the request with no side effects.
  - lock is ignored when req is low.

Test Plan:
- Reset: hold reset 2 cycles with req0 = req1 = 1 and we0 = 1 -> no gnt, mem_wr_en = 0, rvalid = 0, rdata = 0. First cycle after release -> gnt0 = 1.
- Single write/read: req0 write 8'h5A to addr 8'h10 -> gnt0 same cycle, mem_wr_en = 1. Then req0 read addr 8'h10 -> next cycle rvalid0 = 1, rdata = 8'h5A, rvalid1 = 0.
- Round-robin: req0 and req1 both held continuously, no lock -> grants alternate 0,1,0,1 for 8 cycles; never both high.
- Burst lock: MAX_BURST = 4, lock1 = 1 with req0 and req1 held -> gnt1 for exactly 4 consecutive cycles, then gnt0. With req0 low -> gnt1 continuous for 10 cycles.
- Mixed traffic: req1 writes 8'h33 to addr 8'hFF while req0 reads addr 8'hFF on the following grant -> rdata = 8'h33, rvalid0 only.
- Reset mid-burst: assert reset during a locked read burst of req0 -> no mem_wr_en, no rvalid the next cycle; state restarts with requester 0 winning the first tie.
